ssd_scan_driver: RTL
====================

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clocks per digit slot; legal range 2..2^20.
REQ-003 SHALL have port ssd_scan_driver_port_clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port ssd_scan_driver_port_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port ssd_scan_driver_port_inp, input, 4*DIGITS: hex nibbles; digit k = bits [4k+3:4k]; digit 0 is rightmost.
REQ-006 SHALL have port ssd_scan_driver_port_idp, input, DIGITS: per-digit decimal point request; 1 = lit.
REQ-007 SHALL have port ssd_scan_driver_port_blank, input, DIGITS: per-digit forced blank; 1 = dark.
REQ-008 SHALL have port ssd_scan_driver_port_lz, input, 1: leading-zero suppression enable.
REQ-009 SHALL have port ssd_scan_driver_port_cc, output, 7: cathodes, active-low; bit 6 = g … bit 0 = a.
REQ-010 SHALL have port ssd_scan_driver_port_odp, output, 1: decimal-point cathode, active-low.
REQ-011 SHALL have port ssd_scan_driver_port_an, output, DIGITS: anodes, active-low, at most one bit low.
REQ-012 SHALL have port ssd_scan_driver_port_frame, output, 1: one-cycle pulse on each snapshot load.

Function
REQ-013 SHALL count a slot counter 0..REFRESH_DIV-1, wrapping to 0; the width is the minimum for REFRESH_DIV.
REQ-014 SHALL advance the digit index 0→1→…→DIGITS-1→0 in the cycle the slot counter is at REFRESH_DIV-1.
REQ-015 SHALL load a snapshot of inp, idp and blank when the slot counter = REFRESH_DIV-1 and index = DIGITS-1 (end of frame).
REQ-016 SHALL pulse frame high for exactly the cycle after the snapshot load.
REQ-017 SHALL ignore input changes between snapshots; there is no mid-frame tearing.
REQ-018 SHALL register an, cc and odp, each reflecting the current index and snapshot with 1-cycle latency.
REQ-019 SHALL drive an[index] = 0 and all other an bits = 1 for a displayed digit.
REQ-020 SHALL encode cc per hex digit (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 SHALL drive odp = ~idp_snapshot[index] for a displayed digit.
REQ-022 SHALL treat digit k as suppressed when lz = 1, k ≠ 0, and snapshot nibbles DIGITS-1 down to k are all zero; digit 0 is never suppressed.
REQ-023 SHALL, for a blanked or suppressed digit, drive an = all ones, cc = 1111111 and odp = 1 for the whole slot.
REQ-024 SHALL sample lz live, not snapshotted, so suppression changes take effect within 1 cycle.
REQ-025 SHALL, with DIGITS = 1, wrap the index at 0 and load the snapshot every REFRESH_DIV cycles.

Reset
REQ-026 SHALL, while rst is high at a clock edge, clear the slot counter and index to 0, clear the snapshot nibbles and idp to 0, set the snapshot blank to all ones, and drive an = all ones, cc = 1111111, odp = 1 and frame = 0.
REQ-027 SHALL keep the display dark for the first frame after reset; the first real snapshot loads at the end of that frame.
REQ-028 SHALL apply reset asserted mid-frame at the next edge regardless of state; it has priority over snapshot load and index advance.

Verification (DIGITS=4, REFRESH_DIV=4)
REQ-029 SHALL check: rst for 2 cycles, then inp=16'h1234, idp=0, blank=0, lz=0 → dark for 16 cycles, frame pulse, then an cycles 1110/1101/1011/0111 every 4 cycles with cc 0011001/0110000/0100100/1111001.
REQ-030 SHALL check: change inp to 16'hFFFF mid-frame → cc unchanged until the next frame pulse, then 0001110 on all digits.
REQ-031 SHALL check: inp=16'h0050, lz=1 → digits 3 and 2 have an=1111 for their slots, digit 1 shows 0010010, and digit 0 shows 1000000; inp=16'h0000 → only digit 0 is lit.
REQ-032 SHALL check: idp=4'b0100, blank=4'b0001 → odp=0 only during the digit-2 slot, and the digit-0 slot is fully dark.
REQ-033 SHALL check: rst pulsed during the digit-2 slot → the next cycle has an=1111 and cc=1111111, the index restarts at 0, and the frame pulse is 16 cycles after rst falls.
REQ-034 SHALL check: on every cycle, at most one an bit is low and frame is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver: walks one active-low anode per refresh slot
// and shows a frame-coherent snapshot of the hex inputs, with blanking and leading-zero suppression.
module ssd_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  ssd_scan_driver_port_clk,
    input  logic                  ssd_scan_driver_port_rst,
    input  logic [4*DIGITS-1:0]   ssd_scan_driver_port_inp,
    input  logic [DIGITS-1:0]     ssd_scan_driver_port_idp,
    input  logic [DIGITS-1:0]     ssd_scan_driver_port_blank,
    input  logic                  ssd_scan_driver_port_lz,
    output logic [6:0]            ssd_scan_driver_port_cc,
    output logic                  ssd_scan_driver_port_odp,
    output logic [DIGITS-1:0]     ssd_scan_driver_port_an,
    output logic                  ssd_scan_driver_port_frame
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]          slot_q, slot_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0]    snap_inp_q, snap_inp_d;
    logic [DIGITS-1:0]      snap_idp_q, snap_idp_d;
    logic [DIGITS-1:0]      snap_blank_q, snap_blank_d;
    logic [DIGITS-1:0]      an_q, an_d;
    logic [6:0]             cc_q, cc_d;
    logic                   odp_q, odp_d;
    logic                   frame_q;

    logic                   slot_end;
    logic                   frame_end;
    logic [DIGITS-1:0]      zero_above;
    logic                   zero_run;
    logic [3:0]             nibble;
    logic                   dark;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign slot_end  = (slot_q == SLOT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    always_comb begin
        slot_d = slot_end ? '0 : slot_q + 1'b1;
        idx_d  = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Inputs are only captured at the frame boundary so a frame never mixes old and new data.
    always_comb begin
        snap_inp_d   = frame_end ? ssd_scan_driver_port_inp   : snap_inp_q;
        snap_idp_d   = frame_end ? ssd_scan_driver_port_idp   : snap_idp_q;
        snap_blank_d = frame_end ? ssd_scan_driver_port_blank : snap_blank_q;
    end

    // zero_above[k] is set when every snapshot nibble from the top digit down to k is zero.
    always_comb begin
        zero_above = '0;
        zero_run   = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run & (snap_inp_q[4*k +: 4] == 4'h0);
            zero_above[k] = zero_run;
        end
    end

    always_comb begin
        nibble = snap_inp_q[{idx_q, 2'b00} +: 4];
        dark   = snap_blank_q[idx_q]
               | (ssd_scan_driver_port_lz & (idx_q != '0) & zero_above[idx_q]);
        an_d   = '1;
        cc_d   = 7'h7F;
        odp_d  = 1'b1;
        if (!dark) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            cc_d  = hex_to_seg(nibble);
            odp_d = ~snap_idp_q[idx_q];
        end
    end

    always_ff @(posedge ssd_scan_driver_port_clk) begin
        if (ssd_scan_driver_port_rst) begin
            slot_q       <= '0;
            idx_q        <= '0;
            snap_inp_q   <= '0;
            snap_idp_q   <= '0;
            snap_blank_q <= '1;
            an_q         <= '1;
            cc_q         <= 7'h7F;
            odp_q        <= 1'b1;
            frame_q      <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            snap_inp_q   <= snap_inp_d;
            snap_idp_q   <= snap_idp_d;
            snap_blank_q <= snap_blank_d;
            an_q         <= an_d;
            cc_q         <= cc_d;
            odp_q        <= odp_d;
            frame_q      <= frame_end;
        end
    end

    assign ssd_scan_driver_port_an    = an_q;
    assign ssd_scan_driver_port_cc    = cc_q;
    assign ssd_scan_driver_port_odp   = odp_q;
    assign ssd_scan_driver_port_frame = frame_q;

endmodule
